// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM encoding and the mem_ctl request codes.
package dmem_responder_pkg;

    localparam int DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MC_NONE = 2'b00;
    localparam logic [1:0] MC_LD   = 2'b01;
    localparam logic [1:0] MC_ST   = 2'b10;
    localparam logic [1:0] MC_SWP  = 2'b11;

    // Swap sets both bits, so it both reads and writes.
    function automatic logic ctl_reads(input logic [1:0] ctl);
        return ctl[0];
    endfunction

    function automatic logic ctl_writes(input logic [1:0] ctl);
        return ctl[1];
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle between the pipeline and the data memory.
// The pipeline drives requests through master; the responder sits on slave.
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic [1:0]    mem_ctl;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          addr_err;

    modport master (
        output mem_ctl, addr, wdata,
        input  rdata, busy, addr_err
    );

    modport slave (
        input  mem_ctl, addr, wdata,
        output rdata, busy, addr_err
    );

endinterface

// File: rtl/dmem_responder_sram.sv
// Single-port synchronous 2^AW x 32 word array with a registered read port.
// A read and a write at the same index in one cycle return the old word.
module dmem_sram
    import dmem_responder_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          re,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [2**AW];

    // Array contents survive reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (re) begin
            q <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: captures a MEM-stage request, stalls for LAT cycles,
// then performs the load/store/swap against the internal SRAM.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int AW  = 10,
    parameter int LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam logic [3:0] CNT_INIT = (LAT >= 2) ? 4'(LAT - 2) : 4'd0;

    state_t        state, state_d;
    logic [3:0]    cnt, cnt_d;

    logic [1:0]    cap_ctl;
    logic [AW-1:0] cap_idx;
    logic [DW-1:0] cap_wdata;
    logic          cap_err;

    logic          req;
    logic          in_err;
    logic [AW-1:0] in_idx;
    logic          unused_addr_lsb;

    logic          acc;
    logic          busy;
    logic          use_live;
    logic [1:0]    acc_ctl;
    logic [AW-1:0] acc_idx;
    logic [DW-1:0] acc_wdata;
    logic          acc_err;
    logic          addr_err_q;
    logic [DW-1:0] rd_q;

    assign req             = (bus.mem_ctl != MC_NONE);
    assign in_idx          = bus.addr[AW+1:2];
    assign in_err          = ((bus.addr >> (AW + 2)) != '0);
    assign unused_addr_lsb = ^bus.addr[1:0];

    // With LAT==1 the access happens at the capture edge, so the live inputs
    // feed the array; otherwise the captured copy does.
    assign use_live  = (state == ST_IDLE);
    assign acc_ctl   = use_live ? bus.mem_ctl : cap_ctl;
    assign acc_idx   = use_live ? in_idx      : cap_idx;
    assign acc_wdata = use_live ? bus.wdata   : cap_wdata;
    assign acc_err   = use_live ? in_err      : cap_err;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        busy    = 1'b0;
        acc     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req) begin
                    busy = 1'b1;
                    if (LAT == 1) begin
                        acc     = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else begin
                    acc     = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_ctl    <= MC_NONE;
            cap_idx    <= '0;
            cap_wdata  <= '0;
            cap_err    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && req) begin
                cap_ctl   <= bus.mem_ctl;
                cap_idx   <= in_idx;
                cap_wdata <= bus.wdata;
                cap_err   <= in_err;
            end
            addr_err_q <= acc & acc_err;
        end
    end

    // Gating with rst keeps an in-reset cycle from stalling or writing.
    dmem_sram #(.AW(AW)) u_sram (
        .clk   (clk),
        .rst   (rst),
        .re    (rst & acc & ctl_reads(acc_ctl)),
        .we    (rst & acc & ctl_writes(acc_ctl)),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .q     (rd_q)
    );

    assign bus.busy     = rst & busy;
    assign bus.rdata    = rd_q;
    assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LAT=3 and one LAT=1 instance
// driven in turn from a single linear sequence.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dmem_responder_if if3 ();
    dmem_responder_if if1 ();

    dmem_responder #(.AW(10), .LAT(3)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));
    dmem_responder #(.AW(10), .LAT(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit b1, input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] d);
        if (b1) begin
            if1.mem_ctl = ctl; if1.addr = a; if1.wdata = d;
        end else begin
            if3.mem_ctl = ctl; if3.addr = a; if3.wdata = d;
        end
    endtask

    function automatic logic [31:0] get_busy(input bit b1);
        return b1 ? {31'd0, if1.busy} : {31'd0, if3.busy};
    endfunction

    // Issues one request and checks busy for every stall cycle and the DONE
    // cycle; returns at the DONE-cycle negedge with rdata/addr_err sampled.
    task automatic req(input bit b1, input logic [1:0] ctl, input logic [31:0] a,
                       input logic [31:0] d, input int drop_at, input string tag,
                       output logic [31:0] rd, output logic err);
        int lat;
        lat = b1 ? 1 : 3;
        @(posedge clk); #1;
        drive(b1, ctl, a, d);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk($sformatf("%s_busy%0d", tag, i), get_busy(b1), 32'd1);
            @(posedge clk);
            if (i + 1 == drop_at) begin
                #1;
                drive(b1, MC_NONE, a, d);
            end
        end
        @(negedge clk);
        chk({tag, "_done_busy"}, get_busy(b1), 32'd0);
        rd  = b1 ? if1.rdata : if3.rdata;
        err = b1 ? if1.addr_err : if3.addr_err;
    endtask

    task automatic go_idle(input int n);
        @(posedge clk); #1;
        drive(1'b0, MC_NONE, 32'd0, 32'd0);
        drive(1'b1, MC_NONE, 32'd0, 32'd0);
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [31:0] held;

        drive(1'b0, MC_NONE, 32'd0, 32'd0);
        drive(1'b1, MC_NONE, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_busy3", get_busy(1'b0), 32'd0);
        chk("rst_rdata3", if3.rdata, 32'd0);
        chk("rst_err3", {31'd0, if3.addr_err}, 32'd0);
        chk("rst_rdata1", if1.rdata, 32'd0);
        rst = 1'b1;

        // LAT=3: store then load
        req(1'b0, MC_ST, 32'h40, 32'hDEADBEEF, -1, "st40", rd, err);
        chk("st40_rdata", rd, 32'd0);
        chk("st40_err", {31'd0, err}, 32'd0);
        req(1'b0, MC_LD, 32'h40, 32'd0, -1, "ld40", rd, err);
        chk("ld40_rdata", rd, 32'hDEADBEEF);

        // Swap
        req(1'b0, MC_ST, 32'h80, 32'hAAAA0000, -1, "st80", rd, err);
        chk("st80_rdata_hold", rd, 32'hDEADBEEF);
        req(1'b0, MC_SWP, 32'h80, 32'h12345678, -1, "swp80", rd, err);
        chk("swp80_rdata", rd, 32'hAAAA0000);
        req(1'b0, MC_LD, 32'h80, 32'd0, -1, "ld80", rd, err);
        chk("ld80_rdata", rd, 32'h12345678);

        // Out-of-range address wraps and flags addr_err for DONE only
        req(1'b0, MC_ST, 32'h0000_1004, 32'hCAFEF00D, -1, "st1004", rd, err);
        chk("st1004_err", {31'd0, err}, 32'd1);
        go_idle(1);
        @(negedge clk);
        chk("st1004_err_clear", {31'd0, if3.addr_err}, 32'd0);
        req(1'b0, MC_LD, 32'h4, 32'd0, -1, "ld4", rd, err);
        chk("ld4_rdata", rd, 32'hCAFEF00D);
        chk("ld4_err", {31'd0, err}, 32'd0);
        req(1'b0, MC_LD, 32'h7, 32'd0, -1, "ld7", rd, err);
        chk("ld7_rdata", rd, 32'hCAFEF00D);

        // Flush in second WAIT cycle still commits the store
        req(1'b0, MC_ST, 32'h100, 32'h11112222, 2, "flush", rd, err);
        req(1'b0, MC_LD, 32'h100, 32'd0, -1, "ld100", rd, err);
        chk("ld100_rdata", rd, 32'h11112222);

        // Reset during WAIT drops the pending store
        @(posedge clk); #1;
        drive(1'b0, MC_ST, 32'h40, 32'h55555555);
        @(posedge clk); #1;
        chk("rstw_busy_pre", get_busy(1'b0), 32'd1);
        rst = 1'b0;
        #1;
        chk("rstw_busy", get_busy(1'b0), 32'd0);
        chk("rstw_rdata", if3.rdata, 32'd0);
        drive(1'b0, MC_NONE, 32'd0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        req(1'b0, MC_LD, 32'h40, 32'd0, -1, "ld40b", rd, err);
        chk("ld40b_rdata", rd, 32'hDEADBEEF);

        // Idle: nothing moves
        go_idle(1);
        held = if3.rdata;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle_busy%0d", i), get_busy(1'b0), 32'd0);
            chk($sformatf("idle_rdata%0d", i), if3.rdata, held);
        end
        req(1'b0, MC_LD, 32'h80, 32'd0, -1, "ld80b", rd, err);
        chk("ld80b_rdata", rd, 32'h12345678);

        // LAT=1 instance: back-to-back requests
        req(1'b1, MC_ST, 32'h40, 32'h0BADF00D, -1, "l1st", rd, err);
        chk("l1st_rdata", rd, 32'd0);
        req(1'b1, MC_LD, 32'h40, 32'd0, -1, "l1ld", rd, err);
        chk("l1ld_rdata", rd, 32'h0BADF00D);
        req(1'b1, MC_SWP, 32'h40, 32'h00000077, -1, "l1swp", rd, err);
        chk("l1swp_rdata", rd, 32'h0BADF00D);
        req(1'b1, MC_LD, 32'h40, 32'd0, -1, "l1ld2", rd, err);
        chk("l1ld2_rdata", rd, 32'h00000077);
        req(1'b1, MC_ST, 32'h0000_1008, 32'h0F0F0F0F, -1, "l1oor", rd, err);
        chk("l1oor_err", {31'd0, err}, 32'd1);
        req(1'b1, MC_LD, 32'h8, 32'd0, -1, "l1ld8", rd, err);
        chk("l1ld8_rdata", rd, 32'h0F0F0F0F);
        chk("l1ld8_err", {31'd0, err}, 32'd0);
        go_idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
